// File: rtl/prg_ray_sched_if.sv
// Signal bundle between prg_ray_sched (master side) and its surroundings (slave side).
// Valid/ready: a ray moves on a cycle where valid && ready; payload is stable while valid && !ready.
interface prg_ray_sched_if #(
    parameter int RAY_W = 211
);
    logic             frame_start;
    logic             prg_start;
    logic             prg_done;
    logic             prim_valid;
    logic [RAY_W-1:0] prim_ray;
    logic             prg_stall;
    logic             sec_valid;
    logic [RAY_W-1:0] sec_ray;
    logic             sec_ready;
    logic             out_valid;
    logic [RAY_W-1:0] out_ray;
    logic             out_is_prim;
    logic             out_ready;
    logic             frame_done;
    logic             busy;
    logic             ovf_err;
    logic [18:0]      prim_issued;
    logic [31:0]      stall_cycles;
    logic [1:0]       dbg_state;

    modport master (
        input  frame_start, prg_done, prim_valid, prim_ray, sec_valid, sec_ray, out_ready,
        output prg_start, prg_stall, sec_ready, out_valid, out_ray, out_is_prim,
               frame_done, busy, ovf_err, prim_issued, stall_cycles, dbg_state
    );

    modport slave (
        output frame_start, prg_done, prim_valid, prim_ray, sec_valid, sec_ray, out_ready,
        input  prg_start, prg_stall, sec_ready, out_valid, out_ray, out_is_prim,
               frame_done, busy, ovf_err, prim_issued, stall_cycles, dbg_state
    );
endinterface

// File: rtl/prg_ray_sched.sv
// Frame scheduler: buffers prg primary rays in a FIFO and merges them with secondary rays.
// Optional PRG_SCHED_STATS_EN builds the prim_issued / stall_cycles counters (else tied to 0).
module prg_ray_sched #(
    parameter int RAY_W      = 211,
    parameter int DEPTH      = 8,
    parameter int STALL_FREE = 3,
    parameter int SEC_BURST  = 4
) (
    input  logic           clk,
    input  logic           rst,
    prg_ray_sched_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BST_W = $clog2(SEC_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RAY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] free_d;
    logic [BST_W-1:0] burst_q, burst_d;
    logic             out_valid_q, out_valid_d;
    logic [RAY_W-1:0] out_ray_q, out_ray_d;
    logic             out_is_prim_q, out_is_prim_d;
    logic             prg_stall_q, prg_stall_d;
    logic             ovf_err_q, ovf_err_d;

    logic fifo_empty, fifo_full, load, sec_win, take_prim, pop, bypass, push, drop;
    logic prg_start, frame_done;

    // An empty FIFO lets a fresh primary go straight into the output register.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(DEPTH));
        load       = !out_valid_q || bus.out_ready;
        sec_win    = load && bus.sec_valid && (fifo_empty || (burst_q < BST_W'(SEC_BURST)));
        take_prim  = load && !sec_win && (!fifo_empty || bus.prim_valid);
        pop        = take_prim && !fifo_empty;
        bypass     = take_prim && fifo_empty;
        push       = bus.prim_valid && !bypass && (!fifo_full || pop);
        drop       = bus.prim_valid && !bypass && fifo_full && !pop;
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        burst_d       = burst_q;
        out_valid_d   = out_valid_q;
        out_ray_d     = out_ray_q;
        out_is_prim_d = out_is_prim_q;
        ovf_err_d     = ovf_err_q | drop;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);

        if (load) begin
            out_valid_d   = sec_win || take_prim;
            out_is_prim_d = take_prim;
            if (sec_win)  out_ray_d = bus.sec_ray;
            else if (pop) out_ray_d = mem_q[rd_ptr_q];
            else          out_ray_d = bus.prim_ray;
        end

        if (fifo_empty)     burst_d = '0;
        else if (sec_win)   burst_d = burst_q + BST_W'(1);
        else if (take_prim) burst_d = '0;

        free_d      = CNT_W'(DEPTH) - count_d;
        prg_stall_d = (free_d <= CNT_W'(STALL_FREE));
    end

    always_comb begin
        state_d    = state_q;
        prg_start  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    prg_start = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.prg_done) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty && !(out_valid_q && out_is_prim_q)) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            burst_q       <= '0;
            out_valid_q   <= 1'b0;
            out_ray_q     <= '0;
            out_is_prim_q <= 1'b0;
            prg_stall_q   <= 1'b0;
            ovf_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            burst_q       <= burst_d;
            out_valid_q   <= out_valid_d;
            out_ray_q     <= out_ray_d;
            out_is_prim_q <= out_is_prim_d;
            prg_stall_q   <= prg_stall_d;
            ovf_err_q     <= ovf_err_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= bus.prim_ray;
    end

`ifdef PRG_SCHED_STATS_EN
    logic [18:0] prim_issued_q, prim_issued_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        prim_issued_d  = prim_issued_q;
        stall_cycles_d = stall_cycles_q;
        if (prg_start) begin
            prim_issued_d  = '0;
            stall_cycles_d = '0;
        end else begin
            if (out_valid_q && bus.out_ready && out_is_prim_q)
                prim_issued_d = prim_issued_q + 19'd1;
            if (prg_stall_q && (stall_cycles_q != 32'hFFFF_FFFF))
                stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prim_issued_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            prim_issued_q  <= prim_issued_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.prim_issued  = prim_issued_q;
    assign bus.stall_cycles = stall_cycles_q;
`else
    assign bus.prim_issued  = '0;
    assign bus.stall_cycles = '0;
`endif

    // Combinational strobes are masked during reset so an aborted frame never reports.
    assign bus.prg_start   = prg_start && !rst;
    assign bus.frame_done  = frame_done && !rst;
    assign bus.sec_ready   = sec_win && !rst;
    assign bus.prg_stall   = prg_stall_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_ray     = out_ray_q;
    assign bus.out_is_prim = out_is_prim_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.ovf_err     = ovf_err_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_prg_ray_sched.sv
// Self-checking bench for prg_ray_sched: queue-based reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_prg_ray_sched;
    localparam int RAY_W      = 211;
    localparam int DEPTH      = 8;
    localparam int STALL_FREE = 3;
    localparam int SEC_BURST  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prg_ray_sched_if #(.RAY_W(RAY_W)) bus ();

    prg_ray_sched #(
        .RAY_W(RAY_W), .DEPTH(DEPTH), .STALL_FREE(STALL_FREE), .SEC_BURST(SEC_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;

    task automatic chk(input string name, input logic [RAY_W-1:0] act, input logic [RAY_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [RAY_W-1:0] mk_ray(input int id);
        logic [18:0] rid;
        rid = id[18:0];
        return {rid, 96'(id * 3 + 1), 96'(id * 7 + 5)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Reference model: FIFO contents, output register and frame phase, from the behavioural rules.
    logic [RAY_W-1:0] exp_q[$];
    bit               m_out_v    = 1'b0;
    bit               m_out_prim = 1'b0;
    logic [RAY_W-1:0] m_out_ray  = '0;
    bit               m_stall    = 1'b0;
    bit               m_ovf      = 1'b0;
    int               m_burst    = 0;
    int               m_phase    = 0;   // 0 idle, 1 running, 2 draining
    int               m_issued   = 0;
    longint           m_stall_cyc = 0;

    initial begin : model
        bit fempty, load, sec_win, take_prim, e_start, e_done, issue;
        logic [RAY_W-1:0] nxt;
        @(posedge clk);
        forever begin
            @(negedge clk);
            fempty    = (exp_q.size() == 0);
            load      = !m_out_v || bus.out_ready;
            sec_win   = load && bus.sec_valid && (fempty || m_burst < SEC_BURST);
            take_prim = load && !sec_win && (!fempty || bus.prim_valid);
            e_start   = !rst && (m_phase == 0) && bus.frame_start;
            e_done    = !rst && (m_phase == 2) && fempty && !(m_out_v && m_out_prim);

            chk("prg_start",  bus.prg_start,  e_start);
            chk("frame_done", bus.frame_done, e_done);
            chk("sec_ready",  bus.sec_ready,  !rst && sec_win);
            chk("out_valid",  bus.out_valid,  m_out_v);
            if (m_out_v) begin
                chk("out_ray",     bus.out_ray,     m_out_ray);
                chk("out_is_prim", bus.out_is_prim, m_out_prim);
            end
            chk("busy",      bus.busy,      m_phase != 0);
            chk("ovf_err",   bus.ovf_err,   m_ovf);
            chk("prg_stall", bus.prg_stall, m_stall);
`ifdef PRG_SCHED_STATS_EN
            chk("prim_issued",  bus.prim_issued,  m_issued[18:0]);
            chk("stall_cycles", bus.stall_cycles, m_stall_cyc[31:0]);
`else
            chk("prim_issued_tied",  bus.prim_issued,  '0);
            chk("stall_cycles_tied", bus.stall_cycles, '0);
`endif
            if (bus.frame_done === 1'b1) fd_cnt++;

            if (rst) begin
                exp_q.delete();
                m_out_v = 0; m_out_prim = 0; m_out_ray = '0; m_stall = 0; m_ovf = 0;
                m_burst = 0; m_phase = 0; m_issued = 0; m_stall_cyc = 0;
            end else begin
                issue = m_out_v && bus.out_ready && m_out_prim;
                if (e_start) begin
                    m_issued = 0;
                    m_stall_cyc = 0;
                end else begin
                    if (issue) m_issued++;
                    if (m_stall && m_stall_cyc < 64'hFFFF_FFFF) m_stall_cyc++;
                end
                if (load) begin
                    if (sec_win)                nxt = bus.sec_ray;
                    else if (take_prim && !fempty) nxt = exp_q[0];
                    else                        nxt = bus.prim_ray;
                    m_out_v    = sec_win || take_prim;
                    m_out_prim = take_prim;
                    if (m_out_v) m_out_ray = nxt;
                end
                if (take_prim && !fempty) void'(exp_q.pop_front());
                if (bus.prim_valid && !(take_prim && fempty)) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(bus.prim_ray);
                    else m_ovf = 1;
                end
                if (fempty)         m_burst = 0;
                else if (sec_win)   m_burst++;
                else if (take_prim) m_burst = 0;
                m_stall = (DEPTH - exp_q.size()) <= STALL_FREE;
                case (m_phase)
                    0: if (bus.frame_start) m_phase = 1;
                    1: if (bus.prg_done)    m_phase = 2;
                    2: if (e_done)          m_phase = 0;
                    default: m_phase = 0;
                endcase
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        string pat;
        int    fd0;
        bus.frame_start = 0; bus.prg_done = 0; bus.prim_valid = 0; bus.prim_ray = '0;
        bus.sec_valid = 0; bus.sec_ray = '0; bus.out_ready = 0;

        // Reset values
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        neg();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_prg_stall", bus.prg_stall, 0);
        chk("rst_ovf_err",   bus.ovf_err,   0);

        // Frame start: same-cycle pulse, busy next cycle
        step(); bus.frame_start = 1;
        neg();  chk("start_pulse", bus.prg_start, 1);
        step(); bus.frame_start = 0;
        neg();
        chk("busy_after_start", bus.busy, 1);
        chk("start_one_cycle",  bus.prg_start, 0);
        chk("start_no_out",     bus.out_valid, 0);

        // Three primaries, one every third cycle, visible one cycle after push
        step(); bus.out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            bus.prim_valid = 1; bus.prim_ray = mk_ray(k);
            step(); bus.prim_valid = 0;
            neg();
            chk("prim_lat_valid", bus.out_valid, 1);
            chk("prim_order_id",  bus.out_ray[RAY_W-1 -: 19], k);
            chk("prim_is_prim",   bus.out_is_prim, 1);
            step();
            step();
        end
`ifdef PRG_SCHED_STATS_EN
        neg(); chk("prim_issued_3", bus.prim_issued, 3);
        step();
`endif

        // Fill with out_ready low: first ray parks in the output register, rest queue
        bus.out_ready = 0;
        for (int k = 0; k < 10; k++) begin
            bus.prim_valid = 1; bus.prim_ray = mk_ray(10 + k);
            neg();
            if (k == 5) chk("stall_low_4_queued",  bus.prg_stall, 0);
            if (k == 6) chk("stall_high_5_queued", bus.prg_stall, 1);
            if (k == 9) chk("no_ovf_at_full",      bus.ovf_err,   0);
            step();
        end
        bus.prim_valid = 0;
        neg();
        chk("ovf_on_drop",    bus.ovf_err,   1);
        chk("stall_when_full", bus.prg_stall, 1);
        chk("held_payload",   bus.out_ray[RAY_W-1 -: 19], 10);

        // Burst limit: four secondaries then one primary while the FIFO is non-empty
        step(); bus.out_ready = 1; bus.sec_valid = 1;
        pat = "SSSSPSSSSP";
        for (int k = 0; k < 10; k++) begin
            bus.sec_ray = mk_ray(100 + k);
            neg(); chk("grant_seq", bus.sec_ready, pat[k] == "S");
            step();
        end
        bus.sec_valid = 0;

        // Drain to two queued, then prg_done: exactly one frame_done
        repeat (4) step();
        bus.prg_done = 1; fd0 = fd_cnt;
        step(); bus.prg_done = 0;
        repeat (8) step();
        chk("frame_done_once", fd_cnt - fd0, 1);
        chk("idle_after_done", bus.busy, 0);

        // Secondary served while idle
        bus.sec_valid = 1; bus.sec_ray = mk_ray(500);
        neg();  chk("idle_sec_ready", bus.sec_ready, 1);
        step(); bus.sec_valid = 0;
        neg();
        chk("idle_sec_valid", bus.out_valid, 1);
        chk("idle_sec_src",   bus.out_is_prim, 0);
        chk("idle_sec_id",    bus.out_ray[RAY_W-1 -: 19], 500);
        chk("ovf_sticky",     bus.ovf_err, 1);
        step();

        // Mixed traffic over a whole frame
        bus.frame_start = 1;
        step(); bus.frame_start = 0;
        for (int k = 0; k < 150; k++) begin
            bus.prim_valid = ($urandom_range(0, 2) != 0);
            bus.prim_ray   = mk_ray(1000 + k);
            bus.sec_valid  = ($urandom_range(0, 3) == 0);
            bus.sec_ray    = mk_ray(3000 + k);
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.prim_valid = 0; bus.sec_valid = 0; bus.out_ready = 1;
        bus.prg_done = 1;
        step(); bus.prg_done = 0;
        repeat (20) step();
        chk("mixed_frame_ended", bus.busy, 0);

        // Reset mid-frame with queued rays and a held output
        bus.frame_start = 1;
        step(); bus.frame_start = 0; bus.out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            bus.prim_valid = 1; bus.prim_ray = mk_ray(700 + k);
            step();
        end
        bus.prim_valid = 0;
        neg(); chk("pre_rst_out_valid", bus.out_valid, 1);
        step();
        rst = 1; fd0 = fd_cnt;
        step(); rst = 0; bus.out_ready = 1;
        neg();
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_busy",      bus.busy,      0);
        chk("abort_ovf_clear", bus.ovf_err,   0);
        chk("abort_stall",     bus.prg_stall, 0);
        repeat (3) step();
        chk("abort_fifo_empty", bus.out_valid, 0);
        chk("abort_no_done",    fd_cnt - fd0, 0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
